conv_pool_quant: RTL and testbench
==================================

// Module: conv_pool_quant
// PURPOSE
// - Downstream of the depth-wise separable convolution stage; consumes its 32-bit post-ReLU result stream.
// - Applies 1-D max pooling (window POOL, stride POOL) and requantizes each pooled value to 8-bit unsigned.
// - Buffers results in a small FIFO with a ready/valid output.
// - Convolution output has no backpressure, so this block absorbs the rate mismatch and flags lost data.
// PARAMETERS
// - FRAME_LEN  88  input beats per frame (convolution results per frame)
// - POOL       2   pooling window = stride, 1..8
// - DEPTH      8   output FIFO entries, power of 2
// PORTS
// - CLK        in   1   clock, all logic on posedge
// - RESET      in   1   synchronous, active-high reset
// - IN_DATA    in   32  convolution result, unsigned (ReLU'd)
// - IN_VALID   in   1   IN_DATA valid this cycle; no ready back to producer
// - SHIFT      in   5   requant right-shift; sampled on first beat of a frame
// - OUT_DATA   out  8   FIFO head, valid when OUT_VALID=1
// - OUT_VALID  out  1   FIFO non-empty
// - OUT_READY  in   1   consumer accepts head; read occurs when OUT_VALID & OUT_READY
// - FRAME_DONE out  1   one-cycle pulse: frame fully input and FIFO drained
// - OVERFLOW   out  1   sticky: a pooled result or input beat was dropped
// BEHAVIOUR
// - Reset (all outputs): OUT_DATA=0, OUT_VALID=0, FRAME_DONE=0, OVERFLOW=0.
//   Reset also clears FIFO, pointers, counters and partial window; state=IDLE.
//   Reset mid-frame discards all in-flight data.
// - FSM:
//   IDLE  -> RUN on first IN_VALID; latch SHIFT, beat counts as #1.
//   RUN   -> DRAIN after beat FRAME_LEN is accepted.
//   DRAIN -> DONE when the FIFO is empty and no write is pending.
//   DONE  -> IDLE after 1 cycle; FRAME_DONE=1 only in DONE.
// - Beat counting: IN_VALID gaps allowed; only valid beats count.
//   IN_VALID in DRAIN/DONE: beat dropped, OVERFLOW set.
// - Pooling:
//   - Window max register loads on the first beat of a window; unsigned compare on later beats.
//   - Window closes after POOL beats, or at beat FRAME_LEN (partial final window, max of the beats present).
//   - FRAME_LEN=88, POOL=2 gives 44 outputs.
// - Requant: q = pooled >> SHIFT_latched; if q > 255 then 255 (saturate), else q[7:0].
// - Latency: closing beat sampled at edge E0; q written to FIFO at E1; OUT_VALID=1 from E1 (no bypass).
// - FIFO:
//   - Write when full with a simultaneous read: accepted.
//   - Write when full without a read: dropped, OVERFLOW=1.
//   - Read when empty: ignored.
//   - Pointers wrap mod DEPTH; occupancy counter is 0..DEPTH.
// - OVERFLOW stays set until RESET; pooling/output otherwise continue normally.
// - OUT_DATA holds its last value when the FIFO is empty.
// CONFIGURATION
// - Macro: CONV_POOL_ROUND_EN.
// - Defined: round-half-up requant. If SHIFT>0, q = (pooled + (1<<(SHIFT-1))) >> SHIFT,
//   using a 33-bit add (no wrap); saturation applied after rounding. SHIFT=0 is unchanged.
// - Undefined: truncating shift as above; rounding adder not synthesized.
// TESTING
// - T1: beat i = i*256, SHIFT=8, OUT_READY=1, 88 beats -> 44 outputs 1,3,5..87 in order;
//   FRAME_DONE pulses once; OVERFLOW=0.
// - T2: all beats 0x0001_0000, SHIFT=4 -> every OUT_DATA=255 (saturated).
// - T3: OUT_READY=0 for the whole T1 frame, DEPTH=8 -> OVERFLOW=1, OUT_VALID held;
//   release -> exactly 8 reads 1,3..15, then FRAME_DONE.
// - T4: beats 0x18,0x10, SHIFT=4 -> OUT_DATA=1 without CONV_POOL_ROUND_EN, 2 with it.
// - T5: RESET after 30 beats -> next cycle OUT_VALID=0, FIFO empty;
//   fresh 88-beat frame gives exactly 44 outputs.
// - T6: FRAME_LEN=5, POOL=2, beats 9,3,4,8,7, SHIFT=0 -> outputs 9,8,7; 1-cycle IN_VALID gaps give the same result.

Source files
------------

// File: rtl/conv_pool_quant_if.sv
// Stream bundle for conv_pool_quant: unsigned 32-bit input beats in, 8-bit ready/valid results out.
interface conv_pool_quant_if;
  logic [31:0] IN_DATA;
  logic        IN_VALID;
  logic [4:0]  SHIFT;
  logic [7:0]  OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport master (output IN_DATA, IN_VALID, SHIFT, OUT_READY,
                  input  OUT_DATA, OUT_VALID);
  modport slave  (input  IN_DATA, IN_VALID, SHIFT, OUT_READY,
                  output OUT_DATA, OUT_VALID);
endinterface

// File: rtl/conv_pool_quant.sv
// 1-D max pool + 8-bit requantizer with an output FIFO; drops and flags data it cannot absorb.
// Define CONV_POOL_ROUND_EN for round-half-up requantization (default: truncating shift).
module conv_pool_quant #(
  parameter int unsigned FRAME_LEN = 88,
  parameter int unsigned POOL      = 2,
  parameter int unsigned DEPTH     = 8
) (
  input  logic               CLK,
  input  logic               RESET,
  conv_pool_quant_if.slave   bus,
  output logic               FRAME_DONE,
  output logic               OVERFLOW
);
  localparam int unsigned BW = $clog2(FRAME_LEN + 1);
  localparam int unsigned WW = $clog2(POOL + 1);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [BW-1:0] beat_cnt;
  logic [WW-1:0] win_cnt;
  logic [31:0]   win_max;
  logic [4:0]    shift_lat;
  logic          pend_valid;
  logic [7:0]    pend_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [7:0]    last_q;

  logic          accept, last_beat, win_close, fifo_full, rd, wr;
  logic [BW-1:0] beat_num;
  logic [31:0]   pooled;
  logic [4:0]    eff_shift;

  function automatic logic [7:0] requant(input logic [31:0] v, input logic [4:0] s);
    logic [32:0] t;
    t = {1'b0, v};
`ifdef CONV_POOL_ROUND_EN
    if (s != 5'd0) t = t + (33'd1 << (s - 5'd1));
`endif
    t = t >> s;
    return (t > 33'd255) ? 8'hFF : t[7:0];
  endfunction

  always_comb begin
    accept    = bus.IN_VALID && (state == IDLE || state == RUN);
    beat_num  = (state == IDLE) ? BW'(1) : beat_cnt + BW'(1);
    last_beat = accept && (beat_num == BW'(FRAME_LEN));
    win_close = accept && ((win_cnt + WW'(1) == WW'(POOL)) || last_beat);
    pooled    = (win_cnt == '0 || bus.IN_DATA > win_max) ? bus.IN_DATA : win_max;
    // first beat of a frame may also close a window (POOL=1), so use the live SHIFT there
    eff_shift = (state == IDLE) ? bus.SHIFT : shift_lat;
    fifo_full = (fifo_cnt == CW'(DEPTH));
    rd        = (fifo_cnt != '0) && bus.OUT_READY;
    wr        = pend_valid && (!fifo_full || rd);
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, RUN: if (last_beat) state_nxt = DRAIN;
                 else if (accept) state_nxt = RUN;
      DRAIN:     if (fifo_cnt == '0 && !pend_valid) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    FRAME_DONE    = (state == DONE);
    bus.OUT_VALID = (fifo_cnt != '0);
    bus.OUT_DATA  = (fifo_cnt != '0) ? mem[rd_ptr] : last_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      beat_cnt   <= '0;
      win_cnt    <= '0;
      win_max    <= '0;
      shift_lat  <= '0;
      pend_valid <= 1'b0;
      pend_q     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      last_q     <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_num;
        win_cnt  <= win_close ? '0 : win_cnt + WW'(1);
        win_max  <= pooled;
        if (state == IDLE) shift_lat <= bus.SHIFT;
      end
      pend_valid <= win_close;
      pend_q     <= requant(pooled, eff_shift);
      if ((bus.IN_VALID && !accept) || (pend_valid && !wr)) OVERFLOW <= 1'b1;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= mem[rd_ptr];
      end
      fifo_cnt <= fifo_cnt + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= pend_q;
  end
endmodule

// File: tb/tb_conv_pool_quant.sv
// Self-checking bench for conv_pool_quant against a frame-level pooling/requant model.
module tb_conv_pool_quant;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  conv_pool_quant_if b ();
  conv_pool_quant_if b6 ();
  logic fd, ov, fd6, ov6;

  conv_pool_quant #(.FRAME_LEN(88), .POOL(2), .DEPTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .bus(b), .FRAME_DONE(fd), .OVERFLOW(ov));
  conv_pool_quant #(.FRAME_LEN(5), .POOL(2), .DEPTH(8)) dut6 (
    .CLK(CLK), .RESET(RESET), .bus(b6), .FRAME_DONE(fd6), .OVERFLOW(ov6));

`ifdef CONV_POOL_ROUND_EN
  localparam logic [7:0] T4_EXP = 8'd2;
`else
  localparam logic [7:0] T4_EXP = 8'd1;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] beats[$];
  int unsigned exp_q[$];
  logic [7:0]  got[$];
  logic [7:0]  got6[$];
  int done_cnt = 0;
  int done6 = 0;
  bit rand_ready = 0;

  always @(negedge CLK) begin
    if (!RESET) begin
      if (b.OUT_VALID && b.OUT_READY) got.push_back(b.OUT_DATA);
      if (b6.OUT_VALID && b6.OUT_READY) got6.push_back(b6.OUT_DATA);
      if (fd) done_cnt++;
      if (fd6) done6++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned ref_q(longint unsigned v, int unsigned s);
    longint unsigned d;
    longint unsigned r;
    d = 64'd1 << s;
`ifdef CONV_POOL_ROUND_EN
    r = (s == 0) ? v : (v + d / 2) / d;
`else
    r = v / d;
`endif
    return (r > 255) ? 255 : int'(r);
  endfunction

  function automatic void build_exp(int unsigned n, int unsigned pool, int unsigned s);
    exp_q.delete();
    for (int unsigned k = 0; k < n; k += pool) begin
      longint unsigned m = 0;
      for (int unsigned j = k; j < k + pool && j < n; j++)
        if (longint'(beats[j]) > m) m = beats[j];
      exp_q.push_back(ref_q(m, s));
    end
  endfunction

  task automatic step_ready();
    if (rand_ready) b.OUT_READY = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    b.IN_VALID = 0; b.IN_DATA = '0; b.SHIFT = '0;
    b6.IN_VALID = 0; b6.IN_DATA = '0; b6.SHIFT = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  task automatic drive(input bit sel, input int unsigned n, input logic [4:0] s, input bit gaps);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      step_ready();
      if (sel) begin
        b6.IN_VALID = 1; b6.IN_DATA = beats[i]; b6.SHIFT = (i == 0) ? s : 5'($urandom);
      end else begin
        b.IN_VALID = 1; b.IN_DATA = beats[i]; b.SHIFT = (i == 0) ? s : 5'($urandom);
      end
      if (gaps) begin
        @(posedge CLK); #1;
        step_ready();
        if (sel) b6.IN_VALID = 0; else b.IN_VALID = 0;
      end
    end
    @(posedge CLK); #1;
    step_ready();
    if (sel) b6.IN_VALID = 0; else b.IN_VALID = 0;
  endtask

  task automatic wait_done(input bit sel, input int start, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(posedge CLK); #1;
      step_ready();
      if ((sel ? done6 : done_cnt) > start) begin
        ok = 1;
        break;
      end
    end
    repeat (4) @(negedge CLK);
  endtask

  task automatic check_frame(input string name, input bit sel, input int start, input bit ok);
    int n;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done_timeout: FRAME_DONE not seen", name); end
    n = sel ? got6.size() : got.size();
    checks++;
    if (n !== exp_q.size()) begin
      errors++; $display("FAIL %s_count: got %0d outputs, expected %0d", name, n, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < n; i++) begin
      logic [7:0] o;
      o = sel ? got6[i] : got[i];
      checks++;
      if (o !== 8'(exp_q[i])) begin
        errors++; $display("FAIL %s_data[%0d]: got %0d, expected %0d", name, i, o, exp_q[i]);
      end
    end
    checks++;
    if ((sel ? done6 : done_cnt) !== start + 1) begin
      errors++; $display("FAIL %s_done_pulses: got %0d, expected 1", name, (sel ? done6 : done_cnt) - start);
    end
    checks++;
    if ((sel ? ov6 : ov) !== 1'b0) begin
      errors++; $display("FAIL %s_overflow: got %b, expected 0", name, sel ? ov6 : ov);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks += 5;
    if (b.OUT_DATA !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d, expected 0", b.OUT_DATA); end
    if (b.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", b.OUT_VALID); end
    if (fd !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b, expected 0", fd); end
    if (ov !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", ov); end
    if (b6.OUT_VALID !== 1'b0) begin errors++; $display("FAIL reset_out_valid6: got %b, expected 0", b6.OUT_VALID); end
  endtask

  task automatic test_ramp();
    int start; bit ok;
    beats.delete();
    for (int i = 0; i < 88; i++) beats.push_back(32'(i * 256));
    build_exp(88, 2, 8);
    b.OUT_READY = 1; got.delete(); start = done_cnt;
    drive(0, 88, 5'd8, 0);
    wait_done(0, start, 300, ok);
    check_frame("ramp", 0, start, ok);
  endtask

  task automatic test_saturate();
    int start; bit ok;
    beats.delete();
    for (int i = 0; i < 88; i++) beats.push_back(32'h0001_0000);
    build_exp(88, 2, 4);
    b.OUT_READY = 1; got.delete(); start = done_cnt;
    drive(0, 88, 5'd4, 0);
    wait_done(0, start, 300, ok);
    check_frame("saturate", 0, start, ok);
  endtask

  task automatic test_fifo_overflow();
    int start; bit ok;
    do_reset();
    beats.delete();
    for (int i = 0; i < 88; i++) beats.push_back(32'(i * 256));
    build_exp(88, 2, 8);
    b.OUT_READY = 0; got.delete(); start = done_cnt;
    drive(0, 88, 5'd8, 0);
    repeat (4) @(negedge CLK);
    checks += 4;
    if (ov !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", ov); end
    if (b.OUT_VALID !== 1'b1) begin errors++; $display("FAIL ovf_valid_held: got %b, expected 1", b.OUT_VALID); end
    if (b.OUT_DATA !== 8'(exp_q[0])) begin
      errors++; $display("FAIL ovf_head: got %0d, expected %0d", b.OUT_DATA, exp_q[0]);
    end
    if (done_cnt !== start) begin errors++; $display("FAIL ovf_early_done: got %0d pulses, expected 0", done_cnt - start); end
    @(posedge CLK); #1 b.OUT_READY = 1;
    wait_done(0, start, 100, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL ovf_done_timeout: FRAME_DONE not seen"); end
    if (got.size() !== 8) begin errors++; $display("FAIL ovf_reads: got %0d, expected 8", got.size()); end
    if (ov !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", ov); end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== 8'(exp_q[i])) begin
        errors++; $display("FAIL ovf_data[%0d]: got %0d, expected %0d", i, got[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_rounding();
    int start; bit ok;
    beats.delete();
    beats.push_back(32'h18); beats.push_back(32'h10);
    for (int i = 2; i < 88; i++) beats.push_back($urandom_range(0, 8191));
    build_exp(88, 2, 4);
    b.OUT_READY = 1; got.delete(); start = done_cnt;
    drive(0, 88, 5'd4, 0);
    wait_done(0, start, 300, ok);
    checks++;
    if (got.size() == 0 || got[0] !== T4_EXP) begin
      errors++; $display("FAIL round_first: got %0d, expected %0d", (got.size() == 0) ? 0 : got[0], T4_EXP);
    end
    check_frame("round", 0, start, ok);
  endtask

  task automatic test_reset_midframe();
    int start; bit ok; logic [4:0] s;
    beats.delete();
    for (int i = 0; i < 88; i++) beats.push_back($urandom);
    b.OUT_READY = 0;
    drive(0, 30, 5'd20, 0);
    RESET = 1; @(posedge CLK); #1 RESET = 0;
    @(negedge CLK);
    checks += 2;
    if (b.OUT_VALID !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", b.OUT_VALID); end
    if (b.OUT_DATA !== 8'd0) begin errors++; $display("FAIL midreset_data: got %0d, expected 0", b.OUT_DATA); end
    beats.delete();
    for (int i = 0; i < 88; i++) beats.push_back($urandom_range(0, 1 << 16));
    s = 5'($urandom_range(0, 12));
    build_exp(88, 2, s);
    rand_ready = 1; got.delete(); start = done_cnt;
    drive(0, 88, s, 0);
    wait_done(0, start, 400, ok);
    rand_ready = 0;
    check_frame("midreset", 0, start, ok);
  endtask

  task automatic test_random();
    int start; bit ok; logic [4:0] s;
    for (int f = 0; f < 3; f++) begin
      beats.delete();
      for (int i = 0; i < 88; i++) beats.push_back($urandom >> $urandom_range(0, 24));
      s = 5'($urandom_range(0, 31));
      build_exp(88, 2, s);
      rand_ready = 1; got.delete(); start = done_cnt;
      drive(0, 88, s, f[0]);
      wait_done(0, start, 400, ok);
      rand_ready = 0;
      check_frame("random", 0, start, ok);
    end
  endtask

  task automatic test_short_frame();
    int start; bit ok;
    beats.delete();
    beats.push_back(9); beats.push_back(3); beats.push_back(4); beats.push_back(8); beats.push_back(7);
    build_exp(5, 2, 0);
    b6.OUT_READY = 1;
    for (int g = 0; g < 2; g++) begin
      got6.delete(); start = done6;
      drive(1, 5, 5'd0, g[0]);
      wait_done(1, start, 100, ok);
      check_frame(g == 0 ? "short" : "short_gaps", 1, start, ok);
    end
  endtask

  initial begin
    b.OUT_READY = 1; b6.OUT_READY = 1;
    test_reset();
    test_ramp();
    test_saturate();
    test_fifo_overflow();
    test_rounding();
    test_reset_midframe();
    test_random();
    test_short_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
